pix_stream_fbw: RTL and testbench

Converts a valid/ready stream of RGB565 pixels, raster order, into row writes on the HUB75 controller's frame-buffer write port.
- Fills the controller's line buffer one row at a time, then commits each row.
- Requests a frame swap after the last row of each frame.
- Sits between any pixel source (SPI flash reader, UART, video decoder) and `hub75_top`.
- Replaces a pattern/video generator on the `fbw_*` / `frame_*` ports.

---
 rtl/pix_stream_fbw.sv | 194 +++++++++++++++++++
 tb/tb_pix_stream_fbw.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_stream_fbw.sv
// pix_stream_fbw: turns a raster-order RGB565 valid/ready stream into
// line-buffer writes, row commits and frame swaps for the HUB75 controller.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// WAIT_ROW   | waiting for the line buffer to become writable
// FILL       | accepting beats and writing pixels into the line buffer
// FLUSH      | last pixel of the row is on the write port
// STORE      | commit/swap pulse for the current row
// HOLD       | settle cycle; controller's row_rdy is not trusted yet
// WAIT_FRAME | last row committed, waiting for the back buffer
// SWAP       | frame swap pulse; realign to the next SOF
module pix_stream_fbw #(
  parameter int N_ROWS   = 64,
  parameter int N_COLS   = 64,
  parameter int N_PLANES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 in_data,
  input  logic                        in_sof,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [$clog2(N_ROWS)-1:0]   fbw_row_addr,
  output logic                        fbw_row_store,
  input  logic                        fbw_row_rdy,
  output logic                        fbw_row_swap,
  output logic [3*N_PLANES-1:0]       fbw_data,
  output logic [$clog2(N_COLS)-1:0]   fbw_col_addr,
  output logic                        fbw_wren,
  output logic                        frame_swap,
  input  logic                        frame_rdy,
  output logic                        sync_err
);

  localparam int RW = $clog2(N_ROWS);
  localparam int CW = $clog2(N_COLS);
  localparam int DW = 3 * N_PLANES;

  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_WAIT_ROW   = 3'd0,
    S_FILL       = 3'd1,
    S_FLUSH      = 3'd2,
    S_STORE      = 3'd3,
    S_HOLD       = 3'd4,
    S_WAIT_FRAME = 3'd5,
    S_SWAP       = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            synced_q, synced_d;
  logic            wren_q, wren_d;
  logic [CW-1:0]   wcol_q, wcol_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            sync_err_q, sync_err_d;

  logic            beat_acc;
  logic [DW-1:0]   pix_exp;

  // Left-align a channel and refill the vacated LSBs with its own MSBs;
  // taking the top bits of the channel written twice does exactly that.
  function automatic logic [N_PLANES-1:0] expand5(input logic [4:0] v);
    logic [9:0] rep;
    rep = {v, v};
    return rep[9 -: N_PLANES];
  endfunction

  function automatic logic [N_PLANES-1:0] expand6(input logic [5:0] v);
    logic [11:0] rep;
    rep = {v, v};
    return rep[11 -: N_PLANES];
  endfunction

  // Ready depends on registered state only, so the handshake has no
  // combinational path from the source.
  assign in_ready      = (state_q == S_FILL);
  assign beat_acc      = in_valid & in_ready;
  assign pix_exp       = {expand5(in_data[15:11]), expand6(in_data[10:5]), expand5(in_data[4:0])};

  assign fbw_row_store = (state_q == S_STORE);
  assign fbw_row_swap  = (state_q == S_STORE);
  assign fbw_row_addr  = row_q;
  assign frame_swap    = (state_q == S_SWAP);
  assign fbw_wren      = wren_q;
  assign fbw_col_addr  = wcol_q;
  assign fbw_data      = wdata_q;
  assign sync_err      = sync_err_q;

  // Next-state, position counters and registered write-port values.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    synced_d   = synced_q;
    wren_d     = 1'b0;
    wcol_d     = wcol_q;
    wdata_d    = wdata_q;
    sync_err_d = 1'b0;

    unique case (state_q)
      S_WAIT_ROW: begin
        if (fbw_row_rdy) state_d = S_FILL;
      end

      S_FILL: begin
        if (beat_acc) begin
          if (in_sof) begin
            // SOF always restarts at (0,0); an unfinished row is dropped
            // and rows already committed will simply be overwritten.
            sync_err_d = (row_q != '0) || (col_q != '0);
            wren_d     = 1'b1;
            wcol_d     = '0;
            wdata_d    = pix_exp;
            row_d      = '0;
            col_d      = COL_ONE;
            synced_d   = 1'b1;
          end else if (synced_q) begin
            wren_d  = 1'b1;
            wcol_d  = col_q;
            wdata_d = pix_exp;
            if (col_q == COL_LAST) begin
              col_d   = '0;
              state_d = S_FLUSH;
            end else begin
              col_d = col_q + COL_ONE;
            end
          end
        end
      end

      S_FLUSH: begin
        state_d = S_STORE;
      end

      S_STORE: begin
        if (row_q == ROW_LAST) begin
          state_d = S_WAIT_FRAME;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        state_d = S_WAIT_ROW;
      end

      S_WAIT_FRAME: begin
        if (frame_rdy) state_d = S_SWAP;
      end

      S_SWAP: begin
        row_d    = '0;
        col_d    = '0;
        synced_d = 1'b0;
        state_d  = S_WAIT_ROW;
      end

      default: begin
        state_d = S_WAIT_ROW;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_WAIT_ROW;
      row_q      <= '0;
      col_q      <= '0;
      synced_q   <= 1'b0;
      wren_q     <= 1'b0;
      wcol_q     <= '0;
      wdata_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      synced_q   <= synced_d;
      wren_q     <= wren_d;
      wcol_q     <= wcol_d;
      wdata_q    <= wdata_d;
      sync_err_q <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_pix_stream_fbw.sv
// Self-checking bench for pix_stream_fbw: randomized pixel streams compared
// against a raster-position reference model.
module tb_pix_stream_fbw;

  localparam int NR = 64;
  localparam int NC = 64;
  localparam int NP = 8;
  localparam int RW = $clog2(NR);
  localparam int CW = $clog2(NC);
  localparam int DW = 3 * NP;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  typedef struct packed {
    logic [RW-1:0] row;
    int            cyc;
  } st_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   in_data = '0;
  logic          in_sof = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] fbw_row_addr;
  logic          fbw_row_store;
  logic          fbw_row_rdy = 1'b1;
  logic          fbw_row_swap;
  logic [DW-1:0] fbw_data;
  logic [CW-1:0] fbw_col_addr;
  logic          fbw_wren;
  logic          frame_swap;
  logic          frame_rdy = 1'b0;
  logic          sync_err;

  pix_stream_fbw #(.N_ROWS(NR), .N_COLS(NC), .N_PLANES(NP)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .fbw_row_addr(fbw_row_addr),
    .fbw_row_store(fbw_row_store), .fbw_row_rdy(fbw_row_rdy),
    .fbw_row_swap(fbw_row_swap), .fbw_data(fbw_data),
    .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
    .frame_swap(frame_swap), .frame_rdy(frame_rdy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  // reference model state
  wr_t exp_w[$];
  st_t exp_s[$];
  int  acc_cyc[$];
  int  exp_err, exp_frames;
  int  m_row, m_col;
  bit  m_sync;

  // observed events
  wr_t obs_w[$];
  st_t obs_s[$];
  int  obs_fs[$];
  int  obs_err, obs_pair_bad, obs_ready_viol;
  bit  rdy_hold_en = 1'b0;
  int  blk = 0;

  function automatic logic [DW-1:0] exp_pix(input logic [15:0] p);
    int r, g, b, r8, g8, b8;
    logic [31:0] rv, gv, bv;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r8 = (r << (NP - 5)) | (r >> (10 - NP));
    g8 = (g << (NP - 6)) | (g >> (12 - NP));
    b8 = (b << (NP - 5)) | (b >> (10 - NP));
    rv = r8; gv = g8; bv = b8;
    return {rv[NP-1:0], gv[NP-1:0], bv[NP-1:0]};
  endfunction

  // Raster model: an accepted beat at cycle c is written at c+1; the row is
  // committed at c+2 once its last column has been written.
  function automatic void model_accept(input logic [15:0] d, input logic sof, input int c);
    acc_cyc.push_back(c);
    if (sof) begin
      if (m_row != 0 || m_col != 0) exp_err++;
      m_row  = 0;
      m_col  = 0;
      m_sync = 1'b1;
    end
    if (!m_sync) return;
    exp_w.push_back(wr_t'{col: CW'(m_col), data: exp_pix(d), cyc: c + 1});
    m_col++;
    if (m_col == NC) begin
      m_col = 0;
      exp_s.push_back(st_t'{row: RW'(m_row), cyc: c + 2});
      m_row++;
      if (m_row == NR) begin
        m_row  = 0;
        m_sync = 1'b0;
        exp_frames++;
      end
    end
  endfunction

  // Observe the write port away from the active edge; also throttle
  // fbw_row_rdy for 20 cycles after each commit when enabled.
  always @(negedge clk) begin
    if (fbw_wren) obs_w.push_back(wr_t'{col: fbw_col_addr, data: fbw_data, cyc: cyc});
    if (fbw_row_store) obs_s.push_back(st_t'{row: fbw_row_addr, cyc: cyc});
    if (fbw_row_store != fbw_row_swap) obs_pair_bad++;
    if (frame_swap) obs_fs.push_back(cyc);
    if (sync_err) obs_err++;
    if (rdy_hold_en && fbw_row_store) blk = 20;
    if (blk > 0) begin
      fbw_row_rdy = 1'b0;
      blk--;
      if (in_ready) obs_ready_viol++;
    end else begin
      fbw_row_rdy = 1'b1;
    end
  end

  task automatic clear_tb_state();
    exp_w.delete(); exp_s.delete(); acc_cyc.delete();
    obs_w.delete(); obs_s.delete(); obs_fs.delete();
    exp_err = 0; exp_frames = 0; obs_err = 0; obs_pair_bad = 0; obs_ready_viol = 0;
    m_row = 0; m_col = 0; m_sync = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    repeat (2) @(negedge clk);
    clear_tb_state();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  // Offer one beat, with random idle gaps, until the DUT takes it.
  task automatic drive_beat(input logic [15:0] d, input logic sof, input int gap_pct);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        if (in_ready) begin
          model_accept(d, sof, cyc);
          done = 1'b1;
        end
      end
      guard++;
      if (!done && guard > 2000) begin
        n_vec++; n_mis++;
        $display("FAIL beat_accept timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b1; in_data = 16'hFFFF; frame_rdy = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL reset in_ready: got %b, expected 0", in_ready); end
    n_vec++; if (fbw_wren !== 1'b0) begin n_mis++; $display("FAIL reset fbw_wren: got %b, expected 0", fbw_wren); end
    n_vec++; if (fbw_row_store !== 1'b0 || fbw_row_swap !== 1'b0) begin n_mis++; $display("FAIL reset row pulses: got %b%b, expected 00", fbw_row_store, fbw_row_swap); end
    n_vec++; if (fbw_row_addr !== '0 || fbw_col_addr !== '0) begin n_mis++; $display("FAIL reset addr: got row %h col %h, expected 0 0", fbw_row_addr, fbw_col_addr); end
    n_vec++; if (fbw_data !== '0) begin n_mis++; $display("FAIL reset fbw_data: got %h, expected 0", fbw_data); end
    n_vec++; if (frame_swap !== 1'b0 || sync_err !== 1'b0) begin n_mis++; $display("FAIL reset frame_swap/sync_err: got %b%b, expected 00", frame_swap, sync_err); end
    in_valid = 1'b0; in_sof = 1'b0; frame_rdy = 1'b0;
    do_reset();
  endtask

  task automatic test_first_row();
    do_reset();
    for (int c = 0; c < NC; c++) drive_beat(16'hFFFF, c == 0, 0);
    for (int c = 0; c < NC; c++) drive_beat(16'($urandom), 1'b0, 0);
    idle(6);
    n_vec++; if (obs_w.size() != exp_w.size()) begin n_mis++; $display("FAIL first_row write count: got %0d, expected %0d", obs_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      n_vec++; if (obs_w[i] !== exp_w[i]) begin n_mis++; $display("FAIL first_row write %0d: got col %0d data %h cyc %0d, expected col %0d data %h cyc %0d", i, obs_w[i].col, obs_w[i].data, obs_w[i].cyc, exp_w[i].col, exp_w[i].data, exp_w[i].cyc); end
    end
    n_vec++; if (obs_s.size() != exp_s.size()) begin n_mis++; $display("FAIL first_row store count: got %0d, expected %0d", obs_s.size(), exp_s.size()); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_vec++; if (obs_s[i] !== exp_s[i]) begin n_mis++; $display("FAIL first_row store %0d: got row %0d cyc %0d, expected row %0d cyc %0d", i, obs_s[i].row, obs_s[i].cyc, exp_s[i].row, exp_s[i].cyc); end
    end
    n_vec++; if (acc_cyc[NC-1] - acc_cyc[0] != NC - 1) begin n_mis++; $display("FAIL first_row throughput: got %0d cycles, expected %0d", acc_cyc[NC-1] - acc_cyc[0], NC - 1); end
    n_vec++; if (acc_cyc[NC] - acc_cyc[NC-1] != 5) begin n_mis++; $display("FAIL first_row row_gap: got %0d cycles, expected 5", acc_cyc[NC] - acc_cyc[NC-1]); end
    n_vec++; if (obs_pair_bad != 0) begin n_mis++; $display("FAIL first_row store_swap_pair: got %0d differing cycles, expected 0", obs_pair_bad); end
  endtask

  task automatic test_presync();
    do_reset();
    for (int k = 0; k < 3; k++) drive_beat(16'($urandom), 1'b0, 25);
    for (int c = 0; c < NC; c++) drive_beat(16'($urandom), c == 0, 25);
    idle(6);
    n_vec++; if (obs_w.size() != NC) begin n_mis++; $display("FAIL presync write count: got %0d, expected %0d", obs_w.size(), NC); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      n_vec++; if (obs_w[i] !== exp_w[i]) begin n_mis++; $display("FAIL presync write %0d: got col %0d data %h cyc %0d, expected col %0d data %h cyc %0d", i, obs_w[i].col, obs_w[i].data, obs_w[i].cyc, exp_w[i].col, exp_w[i].data, exp_w[i].cyc); end
    end
    n_vec++; if (obs_s.size() != 1 || (obs_s.size() == 1 && obs_s[0] !== exp_s[0])) begin n_mis++; $display("FAIL presync store: got %0d stores, expected 1 at row 0 cyc %0d", obs_s.size(), exp_s[0].cyc); end
    n_vec++; if (obs_err != 0) begin n_mis++; $display("FAIL presync sync_err: got %0d pulses, expected 0", obs_err); end
  endtask

  task automatic test_full_frame();
    int rise;
    do_reset();
    frame_rdy = 1'b0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) drive_beat(16'($urandom), r == 0 && c == 0, 20);
    idle(12);
    n_vec++; if (obs_fs.size() != 0) begin n_mis++; $display("FAIL full_frame early_swap: got %0d swaps, expected 0", obs_fs.size()); end
    @(negedge clk);
    frame_rdy = 1'b1;
    rise = cyc;
    repeat (3) @(negedge clk);
    frame_rdy = 1'b0;
    for (int k = 0; k < 5; k++) drive_beat(16'($urandom), 1'b0, 20);
    for (int c = 0; c < NC; c++) drive_beat(16'($urandom), c == 0, 20);
    idle(6);
    n_vec++; if (obs_fs.size() != 1) begin n_mis++; $display("FAIL full_frame swap count: got %0d, expected 1", obs_fs.size()); end
    n_vec++; if (obs_fs.size() > 0 && obs_fs[0] != rise + 1) begin n_mis++; $display("FAIL full_frame swap cycle: got %0d, expected %0d", obs_fs[0], rise + 1); end
    n_vec++; if (obs_s.size() != NR + 1) begin n_mis++; $display("FAIL full_frame store count: got %0d, expected %0d", obs_s.size(), NR + 1); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_vec++; if (obs_s[i] !== exp_s[i]) begin n_mis++; $display("FAIL full_frame store %0d: got row %0d cyc %0d, expected row %0d cyc %0d", i, obs_s[i].row, obs_s[i].cyc, exp_s[i].row, exp_s[i].cyc); end
    end
    n_vec++; if (obs_w.size() != exp_w.size()) begin n_mis++; $display("FAIL full_frame write count: got %0d, expected %0d", obs_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      n_vec++; if (obs_w[i] !== exp_w[i]) begin n_mis++; $display("FAIL full_frame write %0d: got col %0d data %h cyc %0d, expected col %0d data %h cyc %0d", i, obs_w[i].col, obs_w[i].data, obs_w[i].cyc, exp_w[i].col, exp_w[i].data, exp_w[i].cyc); end
    end
    n_vec++; if (obs_err != 0) begin n_mis++; $display("FAIL full_frame sync_err: got %0d pulses, expected 0", obs_err); end
  endtask

  task automatic test_sync_err();
    do_reset();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < NC; c++) drive_beat(16'($urandom), r == 0 && c == 0, 10);
    for (int c = 0; c < 17; c++) drive_beat(16'($urandom), 1'b0, 10);
    for (int c = 0; c < NC; c++) drive_beat(16'($urandom), c == 0, 10);
    idle(6);
    n_vec++; if (obs_err != 1) begin n_mis++; $display("FAIL sync_err pulses: got %0d, expected 1", obs_err); end
    n_vec++; if (obs_s.size() != 6) begin n_mis++; $display("FAIL sync_err store count: got %0d, expected 6", obs_s.size()); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_vec++; if (obs_s[i] !== exp_s[i]) begin n_mis++; $display("FAIL sync_err store %0d: got row %0d cyc %0d, expected row %0d cyc %0d", i, obs_s[i].row, obs_s[i].cyc, exp_s[i].row, exp_s[i].cyc); end
    end
    n_vec++; if (obs_w.size() != exp_w.size()) begin n_mis++; $display("FAIL sync_err write count: got %0d, expected %0d", obs_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      n_vec++; if (obs_w[i] !== exp_w[i]) begin n_mis++; $display("FAIL sync_err write %0d: got col %0d data %h cyc %0d, expected col %0d data %h cyc %0d", i, obs_w[i].col, obs_w[i].data, obs_w[i].cyc, exp_w[i].col, exp_w[i].data, exp_w[i].cyc); end
    end
  endtask

  task automatic test_row_rdy_low();
    do_reset();
    rdy_hold_en = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NC; c++) drive_beat(16'($urandom), r == 0 && c == 0, (r < 2) ? 0 : 40);
    idle(30);
    rdy_hold_en = 1'b0;
    n_vec++; if (obs_ready_viol != 0) begin n_mis++; $display("FAIL row_rdy_low in_ready: got %0d cycles high, expected 0", obs_ready_viol); end
    n_vec++; if (exp_s.size() > 0 && acc_cyc[NC] != exp_s[0].cyc + 21) begin n_mis++; $display("FAIL row_rdy_low resume: got accept at %0d, expected %0d", acc_cyc[NC], exp_s[0].cyc + 21); end
    n_vec++; if (obs_w.size() != exp_w.size()) begin n_mis++; $display("FAIL row_rdy_low write count: got %0d, expected %0d", obs_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      n_vec++; if (obs_w[i] !== exp_w[i]) begin n_mis++; $display("FAIL row_rdy_low write %0d: got col %0d data %h cyc %0d, expected col %0d data %h cyc %0d", i, obs_w[i].col, obs_w[i].data, obs_w[i].cyc, exp_w[i].col, exp_w[i].data, exp_w[i].cyc); end
    end
    n_vec++; if (obs_s.size() != exp_s.size()) begin n_mis++; $display("FAIL row_rdy_low store count: got %0d, expected %0d", obs_s.size(), exp_s.size()); end
    foreach (exp_s[i]) if (i < obs_s.size()) begin
      n_vec++; if (obs_s[i] !== exp_s[i]) begin n_mis++; $display("FAIL row_rdy_low store %0d: got row %0d cyc %0d, expected row %0d cyc %0d", i, obs_s[i].row, obs_s[i].cyc, exp_s[i].row, exp_s[i].cyc); end
    end
  endtask

  task automatic test_reset_mid_row();
    logic [3*DW+2*RW+2*CW:0] outs;
    do_reset();
    for (int c = 0; c < 30; c++) drive_beat(16'($urandom), c == 0, 0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b0;
    @(negedge clk);
    outs = '0;
    outs = {in_ready, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap, sync_err, fbw_row_addr, fbw_col_addr, fbw_data};
    n_vec++; if (outs !== '0) begin n_mis++; $display("FAIL reset_mid_row outputs: got %h, expected 0", outs); end
    n_vec++; if (obs_w.size() != 30) begin n_mis++; $display("FAIL reset_mid_row pre-reset writes: got %0d, expected 30", obs_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      n_vec++; if (obs_w[i] !== exp_w[i]) begin n_mis++; $display("FAIL reset_mid_row write %0d: got col %0d data %h, expected col %0d data %h", i, obs_w[i].col, obs_w[i].data, exp_w[i].col, exp_w[i].data); end
    end
    clear_tb_state();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < NC; c++) drive_beat(16'($urandom), 1'b0, 10);
    idle(4);
    n_vec++; if (obs_w.size() != 0 || obs_s.size() != 0) begin n_mis++; $display("FAIL reset_mid_row unsynced: got %0d writes %0d stores, expected 0 0", obs_w.size(), obs_s.size()); end
    for (int c = 0; c < NC; c++) drive_beat(16'($urandom), c == 0, 0);
    idle(6);
    n_vec++; if (obs_s.size() != 1 || (obs_s.size() == 1 && obs_s[0] !== exp_s[0])) begin n_mis++; $display("FAIL reset_mid_row store: got %0d stores, expected 1 at row 0 cyc %0d", obs_s.size(), exp_s[0].cyc); end
    n_vec++; if (obs_fs.size() != 0 || obs_err != 0) begin n_mis++; $display("FAIL reset_mid_row swap/err: got %0d swaps %0d errs, expected 0 0", obs_fs.size(), obs_err); end
    n_vec++; if (obs_w.size() != exp_w.size()) begin n_mis++; $display("FAIL reset_mid_row write count: got %0d, expected %0d", obs_w.size(), exp_w.size()); end
    foreach (exp_w[i]) if (i < obs_w.size()) begin
      n_vec++; if (obs_w[i] !== exp_w[i]) begin n_mis++; $display("FAIL reset_mid_row row write %0d: got col %0d data %h cyc %0d, expected col %0d data %h cyc %0d", i, obs_w[i].col, obs_w[i].data, obs_w[i].cyc, exp_w[i].col, exp_w[i].data, exp_w[i].cyc); end
    end
  endtask

  initial begin
    clear_tb_state();
    test_reset();
    test_first_row();
    test_presync();
    test_full_frame();
    test_sync_err();
    test_row_rdy_low();
    test_reset_mid_row();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
